// File: rtl/sample_packet_framer_pkg.sv
// sample_packet_framer_pkg -- widths, sync byte, state codes and packet length shared by analyser and framer.
// Rev 1.0
`default_nettype none

package sample_packet_framer_pkg;

  localparam int         ANA_DATA_WIDTH    = 8;
  localparam int         ANA_TIME_WIDTH    = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         DEFAULT_DROP_W    = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Sync byte + data byte + one byte per timestamp octet.
  function automatic int pkt_bytes(input int time_width);
    return 2 + time_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_packet_framer_sat_counter.sv
// sat_counter -- up counter that sticks at all-ones; synchronous active-low clear.
// Rev 1.0
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_packet_framer.sv
// sample_packet_framer -- frames analyser sample events into sync/data/time byte packets on a valid/ready stream.
// Rev 1.0
`default_nettype none

module sample_packet_framer
  import sample_packet_framer_pkg::*;
#(
  parameter int         DATA_WIDTH = ANA_DATA_WIDTH,
  parameter int         TIME_WIDTH = ANA_TIME_WIDTH,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int         DROP_WIDTH = DEFAULT_DROP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [TIME_WIDTH-1:0] sample_time,
  input  logic                  sample_valid,
  output logic                  data_sent,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int PKT_N      = pkt_bytes(TIME_WIDTH);
  localparam int TIME_BYTES = TIME_WIDTH / 8;
  localparam int IDX_W      = $clog2(PKT_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_N - 1);

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic [TIME_WIDTH-1:0]  hold_time;
  logic [7:0]             byte_sel;
  logic                   xfer;

  assign xfer = (state == ST_SEND) && tx_ready;

  // DONE behaves like IDLE for capture so back-to-back packets need only one idle cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      hold_data <= '0;
      hold_time <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (sample_valid) begin
            hold_data <= sample_data;
            hold_time <= sample_time;
            index     <= '0;
            state     <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (index == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    if (index == IDX_W'(0)) begin
      byte_sel = SYNC_BYTE;
    end else if (index == IDX_W'(1)) begin
      byte_sel = hold_data[7:0];
    end else begin
      for (int k = 0; k < TIME_BYTES; k++) begin
        if (index == IDX_W'(k + 2)) begin
          byte_sel = hold_time[TIME_WIDTH-1-8*k -: 8];
        end
      end
    end
  end

  // All stream outputs decode registered state only; tx_ready never reaches tx_valid.
  assign tx_valid  = (state == ST_SEND);
  assign tx_data   = (state == ST_SEND) ? byte_sel : 8'h00;
  assign data_sent = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  sat_counter #(
    .WIDTH (DROP_WIDTH)
  ) u_drop_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample_valid && (state == ST_SEND)),
    .count (drop_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_sample_packet_framer.sv
// tb_sample_packet_framer -- directed and random stimulus against a byte-queue reference model.
// Rev 1.0
`default_nettype none

module tb_sample_packet_framer;

  localparam int         N    = 6;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sample_data = '0;
  logic [31:0] sample_time = '0;
  logic        sample_valid = 1'b0;
  logic        tx_ready = 1'b0;

  logic        data_sent, tx_valid, busy;
  logic [7:0]  tx_data, drop_count;
  logic        data_sent2, tx_valid2, busy2;
  logic [7:0]  tx_data2;
  logic [1:0]  drop_count2;

  sample_packet_framer dut (
    .clk(clk), .rst(rst), .sample_data(sample_data), .sample_time(sample_time),
    .sample_valid(sample_valid), .data_sent(data_sent), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .drop_count(drop_count)
  );

  // Same stimulus into a narrow-counter instance to see saturation quickly.
  sample_packet_framer #(.DROP_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .sample_data(sample_data), .sample_time(sample_time),
    .sample_valid(sample_valid), .data_sent(data_sent2), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready), .busy(busy2), .drop_count(drop_count2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: bytes still owed by the packet in flight, plus total lost events.
  logic [7:0] exp_q[$];
  int         pending  = 0;
  int         drops    = 0;
  bit         sent_now = 0;
  bit         checking = 0;
  int         packets  = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    bit xfer;
    if (checking) begin
      check("tx_valid", tx_valid, pending > 0);
      check("busy", busy, (pending > 0) || sent_now);
      check("data_sent", data_sent, sent_now);
      check("drop_count", drop_count, sat(drops, 255));
      check("drop_count_w2", drop_count2, sat(drops, 3));
      if (pending > 0) check("tx_data", tx_data, exp_q[0]);
    end
    // Predict what the coming rising edge does.
    if (!rst) begin
      pending  = 0;
      drops    = 0;
      sent_now = 0;
      exp_q.delete();
      checking = 1;
    end else begin
      xfer     = (pending > 0) && tx_ready;
      sent_now = 0;
      if (sample_valid) begin
        if (pending == 0) begin
          exp_q.push_back(SYNC);
          exp_q.push_back(sample_data);
          for (int i = 0; i < 4; i++) exp_q.push_back(8'(sample_time >> (24 - 8 * i)));
          pending = N;
          packets++;
        end else begin
          drops++;
        end
      end
      if (xfer) begin
        void'(exp_q.pop_front());
        pending--;
        if (pending == 0) sent_now = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input logic [31:0] t);
    sample_data  = d;
    sample_time  = t;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (5) tick();

    // Basic packet
    tx_ready = 1'b1;
    pulse(8'd69, 32'h0000_0003);
    repeat (10) tick();

    // Backpressure: three stalled cycles per byte
    pulse(8'd100, 32'h1234_5678);
    for (int c = 0; c < 30; c++) begin
      tx_ready = ((c % 4) == 3);
      tick();
    end
    tx_ready = 1'b1;
    repeat (4) tick();

    // Drops during SEND
    pulse(8'h3C, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) pulse(8'hFF, 32'hFFFF_FFFF);
    repeat (8) tick();

    // Back-to-back: continuous requests; the one landing in DONE starts the next packet
    sample_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample_data = 8'(c + 8'h10);
      sample_time = 32'hA000_0000 + 32'(c);
      tick();
    end
    sample_valid = 1'b0;
    repeat (10) tick();

    // Reset mid-packet after the third byte, then a fresh packet
    pulse(8'h77, 32'h0102_0304);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pulse(8'h88, 32'hCAFE_F00D);
    repeat (10) tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      sample_data  = 8'($urandom);
      sample_time  = $urandom;
      sample_valid = ($urandom_range(7) == 0);
      tx_ready     = ($urandom_range(3) != 0);
      rst          = ($urandom_range(499) != 0);
      tick();
    end
    sample_valid = 1'b0;
    rst          = 1'b1;
    tx_ready     = 1'b1;
    repeat (10) tick();

    check("packets_started", (packets > 20), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
